// File: rtl/drawbridge_pkg.sv
// Shared encodings for the drawbridge controller: FSM state codes and traffic light levels.
package drawbridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t SYNC     = 3'd0;
  localparam state_t FLAT     = 3'd1;
  localparam state_t CLEARING = 3'd2;
  localparam state_t LIFTING  = 3'd3;
  localparam state_t UPRIGHT  = 3'd4;
  localparam state_t LOWERING = 3'd5;
  localparam state_t FAULT    = 3'd6;

  localparam logic RED   = 1'b1;
  localparam logic GREEN = 1'b0;

endpackage

// File: rtl/car_occupancy_counter.sv
// Counts cars on the bridge from per-lane entry/exit loop rising edges, saturating at both ends.
module car_occupancy_counter
  import drawbridge_pkg::*;
#(
  parameter int LANES = 2,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [LANES-1:0] CarIn,
  input  logic [LANES-1:0] CarOut,
  output logic [CNT_W-1:0] CarCount
);

  // Signed headroom so a full-lane burst in either direction never wraps before clamping.
  localparam int SW = CNT_W + $clog2(LANES) + 1;
  localparam logic signed [SW-1:0] MAX_COUNT = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [LANES-1:0]        prev_in;
  logic [LANES-1:0]        prev_out;
  logic [LANES-1:0]        in_edges;
  logic [LANES-1:0]        out_edges;
  logic signed [SW-1:0]    in_cnt;
  logic signed [SW-1:0]    out_cnt;
  logic signed [SW-1:0]    sum;
  logic [CNT_W-1:0]        next_count;

  always_comb begin
    in_edges  = CarIn & ~prev_in;
    out_edges = CarOut & ~prev_out;
    in_cnt    = '0;
    out_cnt   = '0;
    for (int i = 0; i < LANES; i++) begin
      in_cnt  = in_cnt + SW'(in_edges[i]);
      out_cnt = out_cnt + SW'(out_edges[i]);
    end
    sum = $signed({{(SW-CNT_W){1'b0}}, CarCount}) + in_cnt - out_cnt;
    if (sum < 0)
      next_count = '0;
    else if (sum > MAX_COUNT)
      next_count = '1;
    else
      next_count = sum[CNT_W-1:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_in  <= '0;
      prev_out <= '0;
      CarCount <= '0;
    end else begin
      prev_in  <= CarIn;
      prev_out <= CarOut;
      CarCount <= next_count;
    end
  end

endmodule

// File: rtl/drawbridge_ctrl.sv
// Drawbridge sequencing FSM with clearing interval, motion watchdog, latched fault and
// registered Moore outputs; occupancy comes from car_occupancy_counter.
module drawbridge_ctrl
  import drawbridge_pkg::*;
#(
  parameter int LANES         = 2,
  parameter int CNT_W         = 6,
  parameter int CLEAR_CYCLES  = 16,
  parameter int MOTOR_TIMEOUT = 1024
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [LANES-1:0] CarIn,
  input  logic [LANES-1:0] CarOut,
  input  logic             Mode,
  input  logic             PowerButton,
  input  logic             BoatSensor,
  input  logic             High,
  input  logic             Low,
  output logic             Motor,
  output logic             MotorUp,
  output logic             Alarm,
  output logic             TrafficLight,
  output logic             Fault,
  output logic [CNT_W-1:0] CarCount
);

  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);
  localparam int MOT_W = $clog2(MOTOR_TIMEOUT + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [MOT_W-1:0] MOT_LAST = MOT_W'(MOTOR_TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [CLR_W-1:0] clear_timer;
  logic [MOT_W-1:0] motion_timer;
  logic             lift_req;
  logic             moving;
  logic             bridge_empty;
  logic             timeout;
  logic             occupied_open;

  car_occupancy_counter #(
    .LANES (LANES),
    .CNT_W (CNT_W)
  ) u_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .CarIn    (CarIn),
    .CarOut   (CarOut),
    .CarCount (CarCount)
  );

  assign lift_req      = Mode ? PowerButton : BoatSensor;
  assign moving        = (state == LIFTING) || (state == LOWERING);
  assign bridge_empty  = (CarCount == '0);
  assign timeout       = moving && (motion_timer == MOT_LAST);
  assign occupied_open = ((state == LIFTING) || (state == UPRIGHT) || (state == LOWERING))
                         && !bridge_empty;

  always_comb begin
    state_next = state;
    case (state)
      SYNC: begin
        case ({High, Low})
          2'b01:   state_next = FLAT;
          2'b10:   state_next = UPRIGHT;
          2'b00:   state_next = LOWERING;
          default: state_next = FAULT;
        endcase
      end
      FLAT:     if (lift_req) state_next = CLEARING;
      CLEARING: begin
        if (!lift_req)
          state_next = FLAT;
        else if (bridge_empty && (clear_timer == CLR_LAST))
          state_next = LIFTING;
      end
      LIFTING: begin
        if (High)
          state_next = UPRIGHT;
        else if (!lift_req)
          state_next = LOWERING;
      end
      UPRIGHT:  if (!lift_req) state_next = LOWERING;
      LOWERING: begin
        if (Low)
          state_next = FLAT;
        else if (lift_req)
          state_next = LIFTING;
      end
      FAULT:    state_next = FAULT;
      default:  state_next = FAULT;
    endcase
    // Fault conditions override every normal transition once the end-stops have been resolved.
    if ((state != SYNC) && ((High && Low) || timeout || occupied_open))
      state_next = FAULT;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= SYNC;
      clear_timer  <= '0;
      motion_timer <= '0;
    end else begin
      state <= state_next;
      if ((state == CLEARING) && (state_next == CLEARING) && bridge_empty)
        clear_timer <= clear_timer + CLR_W'(1);
      else
        clear_timer <= '0;
      if ((state_next == state) && moving)
        motion_timer <= motion_timer + MOT_W'(1);
      else
        motion_timer <= '0;
    end
  end

  // Outputs lag the state register by one clock so every actuator line is glitch-free.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Motor        <= 1'b0;
      MotorUp      <= 1'b0;
      Alarm        <= 1'b0;
      TrafficLight <= RED;
      Fault        <= 1'b0;
    end else begin
      Motor        <= moving;
      MotorUp      <= (state == LIFTING);
      Alarm        <= (state == CLEARING) || (state == LIFTING) ||
                      (state == LOWERING) || (state == FAULT);
      TrafficLight <= (state == FLAT) ? GREEN : RED;
      Fault        <= (state == FAULT);
    end
  end

endmodule

// File: doc/drawbridge_ctrl.md
# drawbridge_ctrl

Parametrised drawbridge controller with an integrated multi-lane car-occupancy counter, a clearing interval, motor-motion watchdog and a latched fault state. It sits between the bridge sensors (car loops, boat sensor, end-stop switches, operator panel) and the actuators (motor, direction, alarm, traffic light). It supports N car lanes and both automatic (boat sensor) and manual (power button) modes.

## Interface
Parameters:
- LANES, 2, number of car entry/exit sensor pairs
- CNT_W, 6, occupancy counter width
- CLEAR_CYCLES, 16, consecutive empty-bridge cycles needed before lifting
- MOTOR_TIMEOUT, 1024, maximum cycles in LIFTING or LOWERING before fault

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- CarIn  in  LANES  per-lane car-entering sensor, level, synchronous
- CarOut  in  LANES  per-lane car-leaving sensor, level, synchronous
- Mode  in  1  1 = manual (PowerButton), 0 = automatic (BoatSensor)
- PowerButton  in  1  manual lift request, level
- BoatSensor  in  1  boat present, level
- High  in  1  bridge fully raised end-stop
- Low  in  1  bridge fully lowered end-stop
- Motor  out  1  motor enable
- MotorUp  out  1  direction: 1 = raise, 0 = lower, meaningful only when Motor = 1
- Alarm  out  1  audible/visual alarm
- TrafficLight  out  1  1 = red (stop cars), 0 = green
- Fault  out  1  latched fault indicator
- CarCount  out  CNT_W  current bridge occupancy

## Operation
- LiftReq = Mode ? PowerButton : BoatSensor. This signal is combinational and sampled every cycle.
- Occupancy counter:
  - A car event is a rising edge on a CarIn/CarOut bit, detected against the registered previous value.
  - Next count = count + popcount(in edges) − popcount(out edges), computed at CNT_W+$clog2(LANES)+1 signed width.
  - The result saturates at 0 and at 2^CNT_W−1.
  - Simultaneous in and out edges on the same cycle net out.
- States: SYNC, FLAT, CLEARING, LIFTING, UPRIGHT, LOWERING, FAULT.
- SYNC (entered from reset, one cycle): the next state is resolved from the end-stops:
  - Low only → FLAT
  - High only → UPRIGHT
  - neither → LOWERING
  - both → FAULT
- FLAT: light green, motor off, no alarm. LiftReq → CLEARING.
- CLEARING: light red, alarm on, motor off.
  - !LiftReq → FLAT.
  - Clear timer counts while CarCount == 0 and resets to 0 when CarCount ≠ 0.
  - When the timer reaches CLEAR_CYCLES−1 → LIFTING.
- LIFTING: Motor = 1, MotorUp = 1, light red, alarm on.
  - High → UPRIGHT.
  - !LiftReq → LOWERING (reversal).
- UPRIGHT: motor off, light red, alarm off. !LiftReq → LOWERING.
- LOWERING: Motor = 1, MotorUp = 0, light red, alarm on.
  - Low → FLAT.
  - LiftReq → LIFTING.
- FAULT: Motor = 0, Alarm = 1, light red, Fault = 1. This state is left only by Reset.
- Fault entry, from any state except SYNC, checked in priority order:
  1. High && Low
  2. motion timer reaches MOTOR_TIMEOUT−1 in LIFTING or LOWERING
  3. CarCount ≠ 0 in LIFTING, UPRIGHT or LOWERING
- The motion timer clears on every state change.

## Timing
- All outputs are registered Moore outputs decoded from the state register. An input change is reflected on the outputs on the clock edge after the transition edge (2-cycle input-to-output latency).
- Reset values:
  - state SYNC
  - Motor 0, MotorUp 0, Alarm 0, TrafficLight 1, Fault 0
  - CarCount 0, both timers 0
- A car edge on cycle n appears on CarCount at cycle n+1 and in the state logic at cycle n+1.
- A minimum of CLEAR_CYCLES cycles is spent in CLEARING. LiftReq dropping on the final cycle wins: the next state is FLAT.
- End-stop and reversal requests on the same cycle: the end-stop wins (LIFTING with High and !LiftReq → UPRIGHT).
- Reset asserted mid-motion: Motor drops asynchronously.

## Structure
- Package drawbridge_pkg holds:
  - the state enum (3 bits)
  - the light encoding constants RED = 1, GREEN = 0
- Sub-module car_occupancy_counter (LANES, CNT_W): edge detect, popcount, saturating up/down counter, Clk/Reset.
- drawbridge_ctrl contains the FSM, the clear timer, the motion timer and the output decode.

## Test plan
- Reset with Low = 1, then BoatSensor = 1 in auto mode, bridge empty → CLEARING for 16 cycles, then LIFTING with Motor = 1, MotorUp = 1; High = 1 → UPRIGHT with Motor = 0, TrafficLight = 1.
- Lanes 0 and 1 pulse CarIn, lane 0 pulses CarOut, during CLEARING → CarCount 2 then 1; no LIFTING until CarCount returns to 0 and 16 further cycles elapse.
- In LIFTING, BoatSensor drops → LOWERING (MotorUp = 0); Low = 1 → FLAT, TrafficLight = 0, Alarm = 0.
- Manual mode, PowerButton = 1, BoatSensor = 0 → lifts; BoatSensor toggling has no effect.
- In LIFTING, hold High = Low = 0 for 1024 cycles → FAULT with Fault = 1, Motor = 0; stays in FAULT until Reset.
- CarOut pulse with CarCount = 0 → stays 0; 70 CarIn pulses with CNT_W = 6 → saturates at 63. High = Low = 1 → FAULT.
